// File: rtl/fwd_pkg.sv
// Shared encodings and the shadow-pipeline entry type for the forwarding scoreboard.
// Entry fields are sized for the widest supported configuration; narrower designs zero-extend.
package fwd_pkg;

    localparam int SEL_RF     = 0;
    localparam int REG_ZERO   = 0;
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_SEL_W  = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [MAX_ADDR_W-1:0] dst;
        logic [MAX_SEL_W-1:0]  rdy;
    } fwd_entry_t;

    function automatic int sel_link(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/fwd_operand_match.sv
// Priority scan of the shadow pipeline for one decode operand: youngest match decides
// between a stage bypass and a hazard; the link path is only a fallback.
module fwd_operand_match
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31,
    parameter int SEL_W    = $clog2(DEPTH + 2)
) (
    input  fwd_entry_t [DEPTH-1:0] entries,
    input  logic [ADDR_W-1:0]      src,
    input  logic                   used,
    input  logic                   link_wen_w,
    output logic [SEL_W-1:0]       sel,
    output logic                   hazard
);

    logic found;

    // NOTE: every output of this block gets a default before any branch, so no latch can form.
    always_comb begin
        found  = 1'b0;
        sel    = SEL_W'(SEL_RF);
        hazard = 1'b0;
        if (used && src != ADDR_W'(REG_ZERO)) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && entries[k-1].valid && entries[k-1].wen &&
                    entries[k-1].dst == MAX_ADDR_W'(src)) begin
                    found = 1'b1;
                    if (MAX_SEL_W'(k) >= entries[k-1].rdy) sel = SEL_W'(k);
                    else                                    hazard = 1'b1;
                end
            end
            if (!found && link_wen_w && src == ADDR_W'(LINK_REG))
                sel = SEL_W'(sel_link(DEPTH));
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Shadow pipeline of in-flight destination tags driving decode bypass selects and
// load-use / multi-cycle stalls, plus a saturating stalled-cycle counter.
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2,
    parameter int LINK_REG = 31,
    parameter int SEL_W    = $clog2(DEPTH + 2),
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_wen,
    input  logic [ADDR_W-1:0]         id_dst,
    input  logic [SEL_W-1:0]          id_rdy_stage,
    input  logic                      flush,
    input  logic                      link_wen_w,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    fwd_entry_t [DEPTH-1:0] entries;
    fwd_entry_t             ins;
    logic [NUM_SRC-1:0]     hazard;
    logic                   insert;

    assign insert = id_valid & ~stall & ~flush;

    // A ready stage of 0 means "forwardable from stage 1"; normalise it on entry.
    always_comb begin
        ins       = '0;
        ins.valid = insert;
        ins.wen   = id_wen;
        ins.dst   = MAX_ADDR_W'(id_dst);
        ins.rdy   = (id_rdy_stage == '0) ? MAX_SEL_W'(1) : MAX_SEL_W'(id_rdy_stage);
    end

    // NOTE: only the valid bits matter after reset, but clearing whole entries keeps the
    // tag compare free of X in simulation; this is a few flops, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            // NOTE: non-blocking assignment makes every stage shift from its old neighbour.
            entries[0] <= ins;
            for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
        fwd_operand_match #(
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .LINK_REG(LINK_REG),
            .SEL_W   (SEL_W)
        ) u_match (
            .entries   (entries),
            .src       (id_src[g*ADDR_W +: ADDR_W]),
            .used      (id_src_used[g]),
            .link_wen_w(link_wen_w),
            .sel       (fwd_sel[g*SEL_W +: SEL_W]),
            .hazard    (hazard[g])
        );
    end

    assign stall = id_valid & ~flush & (|hazard);

    always_ff @(posedge clk) begin
        if (rst)                             stall_cnt <= '0;
        else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
    end

    rdy_stage_legal: assert property (@(posedge clk) disable iff (rst)
        (id_valid && id_wen) |-> (id_rdy_stage <= SEL_W'(DEPTH)));

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: the driver queues hand-computed expectations per cycle, and a
// monitor on the falling edge pops and compares them against the DUT outputs.
module tb_fwd_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [2*ADDR_W-1:0] id_src;
    logic [1:0]          id_src_used;
    logic                id_wen;
    logic [ADDR_W-1:0]   id_dst;
    logic [SEL_W-1:0]    id_rdy_stage;
    logic                flush;
    logic                link_wen_w;
    logic [2*SEL_W-1:0]  fwd_sel;
    logic                stall;
    logic [CNT_W-1:0]    stall_cnt;

    typedef struct {
        string      name;
        logic [2:0] e0;
        logic [2:0] e1;
        logic       est;
        logic [3:0] ecnt;
    } exp_t;

    exp_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(3), .NUM_SRC(2), .LINK_REG(31),
                            .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_wen      (id_wen),
        .id_dst      (id_dst),
        .id_rdy_stage(id_rdy_stage),
        .flush       (flush),
        .link_wen_w  (link_wen_w),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string nm, input int act, input int exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, ".sel0"},  int'(fwd_sel[2:0]), int'(e.e0));
                check({e.name, ".sel1"},  int'(fwd_sel[5:3]), int'(e.e1));
                check({e.name, ".stall"}, int'(stall),        int'(e.est));
                check({e.name, ".cnt"},   int'(stall_cnt),    int'(e.ecnt));
            end
        end
    end

    task automatic step(input string nm, input logic v, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used, input logic wen,
                        input logic [4:0] dst, input logic [2:0] rdy, input logic fl,
                        input logic lk, input logic r, input logic [2:0] e0,
                        input logic [2:0] e1, input logic est, input logic [3:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_valid     = v;
        id_src       = {s1, s0};
        id_src_used  = used;
        id_wen       = wen;
        id_dst       = dst;
        id_rdy_stage = rdy;
        flush        = fl;
        link_wen_w   = lk;
        e.name = nm; e.e0 = e0; e.e1 = e1; e.est = est; e.ecnt = ecnt;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] ecnt);
        repeat (n) step("idle", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, ecnt);
    endtask

    initial begin
        int c;
        rst = 1'b1; id_valid = 0; id_src = '0; id_src_used = '0; id_wen = 0;
        id_dst = '0; id_rdy_stage = '0; flush = 0; link_wen_w = 0;
        repeat (2) @(posedge clk);

        //   name       v  s0  s1  used  wen dst rdy fl lk r   e0 e1 st cnt
        step("rst_st",  1, 5,  31, 2'b11, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0);
        step("rst_lk",  1, 5,  31, 2'b11, 0, 0,  0,  0, 1, 0,  0, 4, 0, 0);
        idle(3, 0);

        // ALU result walking E -> M -> W -> gone
        step("t1_ins",  1, 0,  0,  2'b00, 1, 5,  1,  0, 0, 0,  0, 0, 0, 0);
        step("t1_e",    1, 5,  0,  2'b01, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0);
        step("t1_m",    1, 5,  0,  2'b01, 0, 0,  0,  0, 0, 0,  2, 0, 0, 0);
        step("t1_w",    1, 5,  0,  2'b01, 0, 0,  0,  0, 0, 0,  3, 0, 0, 0);
        step("t1_gone", 1, 5,  0,  2'b01, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0);
        idle(3, 0);

        // load-use: one stall, then forward from M
        step("t2_ld",   1, 0,  0,  2'b00, 1, 7,  2,  0, 0, 0,  0, 0, 0, 0);
        step("t2_haz",  1, 0,  7,  2'b10, 0, 0,  0,  0, 0, 0,  0, 0, 1, 0);
        step("t2_fwd",  1, 0,  7,  2'b10, 0, 0,  0,  0, 0, 0,  0, 2, 0, 1);
        idle(3, 1);

        // youngest match wins, both for forwarding and for hazards
        step("t3_i0",   1, 0,  0,  2'b00, 1, 3,  1,  0, 0, 0,  0, 0, 0, 1);
        step("t3_i1",   1, 3,  0,  2'b01, 1, 3,  1,  0, 0, 0,  1, 0, 0, 1);
        step("t3_yng",  1, 3,  0,  2'b01, 0, 0,  0,  0, 0, 0,  1, 0, 0, 1);
        step("t3_unus", 1, 3,  0,  2'b00, 1, 3,  2,  0, 0, 0,  0, 0, 0, 1);
        step("t3_yhaz", 1, 3,  0,  2'b01, 0, 0,  0,  0, 0, 0,  0, 0, 1, 1);
        step("t3_yfwd", 1, 3,  0,  2'b01, 0, 0,  0,  0, 0, 0,  2, 0, 0, 2);
        idle(3, 2);

        // r0 never forwards; link path is a fallback behind the pipeline
        step("t4_r0i",  1, 0,  0,  2'b00, 1, 0,  1,  0, 0, 0,  0, 0, 0, 2);
        step("t4_r0",   1, 0,  0,  2'b01, 0, 0,  0,  0, 0, 0,  0, 0, 0, 2);
        step("t4_lk",   1, 0,  31, 2'b10, 0, 0,  0,  0, 1, 0,  0, 4, 0, 2);
        step("t4_r31i", 1, 0,  0,  2'b00, 1, 31, 1,  0, 0, 0,  0, 0, 0, 2);
        step("t4_lkpp", 1, 0,  31, 2'b10, 0, 0,  0,  0, 1, 0,  0, 1, 0, 2);
        step("t4_lkun", 1, 0,  31, 2'b00, 0, 0,  0,  0, 1, 0,  0, 0, 0, 2);
        step("t4_rdy0", 1, 0,  0,  2'b00, 1, 5,  0,  0, 0, 0,  0, 0, 0, 2);
        step("t4_r0fw", 1, 5,  0,  2'b01, 0, 0,  0,  0, 0, 0,  1, 0, 0, 2);
        idle(3, 2);

        // flush beats stall and the flushed dst never enters the pipeline
        step("t5_ld",   1, 0,  0,  2'b00, 1, 9,  2,  0, 0, 0,  0, 0, 0, 2);
        step("t5_fl",   1, 9,  0,  2'b01, 1, 12, 1,  1, 0, 0,  0, 0, 0, 2);
        step("t5_post", 1, 12, 9,  2'b11, 0, 0,  0,  0, 0, 0,  0, 2, 0, 2);
        step("t5_nofw", 1, 12, 0,  2'b01, 0, 0,  0,  0, 0, 0,  0, 0, 0, 2);
        idle(3, 2);

        // reset in the middle of a stall drops the pending load
        step("t5_rld",  1, 0,  0,  2'b00, 1, 9,  2,  0, 0, 0,  0, 0, 0, 2);
        step("t5_rhaz", 1, 9,  0,  2'b01, 0, 0,  0,  0, 0, 1,  0, 0, 1, 2);
        step("t5_rpst", 1, 9,  31, 2'b11, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0);

        // back-to-back rdy=3 loads on r6: two stalls per three cycles until saturation
        step("t6_ins",  1, 6,  0,  2'b01, 1, 6,  3,  0, 0, 0,  0, 0, 0, 0);
        c = 0;
        for (int t = 1; t <= 30; t++) begin
            if ((t - 1) % 3 < 2) begin
                step("t6_stl", 1, 6, 0, 2'b01, 1, 6, 3, 0, 0, 0, 0, 0, 1, 4'(c));
                c = (c == 15) ? 15 : c + 1;
            end else begin
                step("t6_fwd", 1, 6, 0, 2'b01, 1, 6, 3, 0, 0, 0, 3, 0, 0, 4'(c));
            end
        end

        @(posedge clk);
        #1;
        id_valid = 0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
